// File: rtl/ttc_chanb_pkg.sv
// Shared constants, types and helpers for the TTC Channel B loopback scheduler.
package ttc_chanb_pkg;

    localparam logic [5:0] CHANB_TS_RESET    = 6'b001010;
    localparam logic       CHANB_FILL_PREFIX = 1'b1;

    // Fill types; 00 is not a legal fill and is rejected at the request port.
    localparam logic [1:0] FILL_NONE     = 2'b00;
    localparam logic [1:0] MUON          = 2'b01;
    localparam logic [1:0] LASER         = 2'b10;
    localparam logic [1:0] PEDESTAL      = 2'b11;

    // Bit positions inside the {fill, ts, evt} pending vector.
    localparam int unsigned PEND_EVT  = 0;
    localparam int unsigned PEND_TS   = 1;
    localparam int unsigned PEND_FILL = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } chanb_state_e;

    // One broadcast slot as seen by the Channel B receiver.
    typedef struct packed {
        logic [5:0] info;
        logic       evt_reset;
    } chanb_slot_t;

    function automatic logic [5:0] fill_payload(input logic [1:0] ft);
        return {CHANB_FILL_PREFIX, ft, 3'b000};
    endfunction

endpackage

// File: rtl/ttc_chanb_loopback_scheduler_sat_counter.sv
// Saturating up-counter with a multi-unit increment per cycle.
module sat_counter #(
    parameter int unsigned W     = 16,
    parameter int unsigned INC_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INC_W-1:0] i_inc,
    output logic [W-1:0]     o_count
);

    logic [W-1:0] r_count;
    logic [W:0]   w_sum;

    assign w_sum   = {1'b0, r_count} + (W+1)'(i_inc);
    assign o_count = r_count;

    // Accumulate, clamping at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_sum[W]) begin
            r_count <= '1;
        end else begin
            r_count <= w_sum[W-1:0];
        end
    end

endmodule

// File: rtl/ttc_chanb_loopback_scheduler.sv
// Local TTC Channel B broadcast generator for loopback mode: arbitrates
// event-reset / timestamp-reset / fill-type requests into spaced strobes.
module ttc_chanb_loopback_scheduler
    import ttc_chanb_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 44,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             req_evt_reset,
    input  logic             req_ts_reset,
    input  logic             req_fill,
    input  logic [1:0]       req_fill_type,
    output logic [5:0]       chan_b_info,
    output logic             chan_b_valid,
    output logic             evt_count_reset,
    output logic             busy,
    output logic [2:0]       pending,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] coalesce_count
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    chanb_state_e r_state, w_state_nxt;
    logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic [2:0]       r_pending, w_pending_nxt;
    logic [1:0]       r_fill_type, w_fill_type_nxt;
    logic             r_valid, w_valid_nxt;
    chanb_slot_t      r_slot, w_slot_nxt;

    logic             w_fill_ok;
    logic [2:0]       w_incoming;
    logic [2:0]       w_merged;
    logic             w_launch;
    logic [1:0]       w_drop_inc;
    logic [1:0]       w_coal_inc;

    assign w_fill_ok  = req_fill && (req_fill_type != FILL_NONE);
    assign w_incoming = {w_fill_ok, req_ts_reset, req_evt_reset};
    assign w_merged   = r_pending | w_incoming;

    // Next state, slot selection and pending bookkeeping.
    always_comb begin
        w_state_nxt     = r_state;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_pending_nxt   = w_merged;
        w_fill_type_nxt = w_fill_ok ? req_fill_type : r_fill_type;
        w_valid_nxt     = 1'b0;
        w_slot_nxt      = '0;
        w_launch        = 1'b0;

        case (r_state)
            IDLE: begin
                w_launch = 1'b1;
            end
            STROBE: begin
                w_state_nxt   = GAP;
                w_gap_cnt_nxt = '0;
            end
            GAP: begin
                // Expiry falls straight into the IDLE decision so backlog
                // strobes land exactly GAP_CYCLES apart.
                if (r_gap_cnt == GAP_W'(GAP_CYCLES - 2)) begin
                    w_state_nxt = IDLE;
                    w_launch    = 1'b1;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_launch && (|w_merged)) begin
            w_state_nxt = STROBE;
            w_valid_nxt = 1'b1;
            if (w_merged[PEND_TS] || w_merged[PEND_EVT]) begin
                w_slot_nxt.info          = w_merged[PEND_TS] ? CHANB_TS_RESET : 6'b000000;
                w_slot_nxt.evt_reset     = w_merged[PEND_EVT];
                w_pending_nxt[PEND_TS]   = 1'b0;
                w_pending_nxt[PEND_EVT]  = 1'b0;
            end else begin
                w_slot_nxt.info          = fill_payload(w_fill_type_nxt);
                w_pending_nxt[PEND_FILL] = 1'b0;
            end
        end

        if (!enable) begin
            w_state_nxt     = IDLE;
            w_gap_cnt_nxt   = '0;
            w_pending_nxt   = '0;
            w_fill_type_nxt = r_fill_type;
            w_valid_nxt     = 1'b0;
            w_slot_nxt      = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gap_cnt   <= '0;
            r_pending   <= '0;
            r_fill_type <= MUON;
            r_valid     <= 1'b0;
            r_slot      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_pending   <= w_pending_nxt;
            r_fill_type <= w_fill_type_nxt;
            r_valid     <= w_valid_nxt;
            r_slot      <= w_slot_nxt;
        end
    end

    // Drops: every request line while disabled, or an illegal fill type.
    always_comb begin
        if (enable) begin
            w_drop_inc = 2'(req_fill && (req_fill_type == FILL_NONE));
            w_coal_inc = 2'(w_incoming[PEND_EVT]  & r_pending[PEND_EVT])
                       + 2'(w_incoming[PEND_TS]   & r_pending[PEND_TS])
                       + 2'(w_incoming[PEND_FILL] & r_pending[PEND_FILL]);
        end else begin
            w_drop_inc = 2'(req_evt_reset) + 2'(req_ts_reset) + 2'(req_fill);
            w_coal_inc = 2'b00;
        end
    end

    sat_counter #(.W(CNT_W), .INC_W(2)) u_drop_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_drop_inc),
        .o_count (drop_count)
    );

    sat_counter #(.W(CNT_W), .INC_W(2)) u_coal_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_coal_inc),
        .o_count (coalesce_count)
    );

    assign chan_b_valid    = r_valid;
    assign chan_b_info     = r_slot.info;
    assign evt_count_reset = r_slot.evt_reset;
    assign busy            = (r_state != IDLE);
    assign pending         = r_pending;

endmodule

// File: tb/tb_ttc_chanb_loopback_scheduler.sv
// Directed bench for the Channel B loopback scheduler.
module tb_ttc_chanb_loopback_scheduler;

    localparam int unsigned GAP = 44;
    localparam int unsigned CW  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          req_evt_reset;
    logic          req_ts_reset;
    logic          req_fill;
    logic [1:0]    req_fill_type;
    logic [5:0]    chan_b_info;
    logic          chan_b_valid;
    logic          evt_count_reset;
    logic          busy;
    logic [2:0]    pending;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] coalesce_count;

    int n_checks = 0;
    int n_errors = 0;

    ttc_chanb_loopback_scheduler #(.GAP_CYCLES(GAP), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .req_evt_reset   (req_evt_reset),
        .req_ts_reset    (req_ts_reset),
        .req_fill        (req_fill),
        .req_fill_type   (req_fill_type),
        .chan_b_info     (chan_b_info),
        .chan_b_valid    (chan_b_valid),
        .evt_count_reset (evt_count_reset),
        .busy            (busy),
        .pending         (pending),
        .drop_count      (drop_count),
        .coalesce_count  (coalesce_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        req_evt_reset = 1'b0;
        req_ts_reset  = 1'b0;
        req_fill      = 1'b0;
        req_fill_type = 2'b00;
    endtask

    task automatic run_quiet(input int n, output int nv);
        nv = 0;
        repeat (n) begin
            tick();
            if (chan_b_valid) nv++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy && i < 200) begin
            tick();
            i++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int nb;
        int nv;

        // Reset state
        reset  = 1'b1;
        enable = 1'b0;
        clear_reqs();
        tick();
        tick();
        chk("rst_valid", 32'(chan_b_valid), 32'd0);
        chk("rst_info", 32'(chan_b_info), 32'd0);
        chk("rst_ecr", 32'(evt_count_reset), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_coal", 32'(coalesce_count), 32'd0);

        reset  = 1'b0;
        enable = 1'b1;
        repeat (8) tick();

        // Single timestamp reset: strobe next cycle, busy for GAP cycles
        req_ts_reset = 1'b1;
        tick();
        clear_reqs();
        chk("ts_valid", 32'(chan_b_valid), 32'd1);
        chk("ts_info", 32'(chan_b_info), 32'h0A);
        chk("ts_ecr", 32'(evt_count_reset), 32'd0);
        chk("ts_pending", 32'(pending), 32'd0);
        nb = 1;
        nv = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!busy) break;
            nb++;
            if (chan_b_valid) nv++;
        end
        chk("ts_busy_len", 32'(nb), 32'(GAP));
        chk("ts_gap_quiet", 32'(nv), 32'd0);
        chk("ts_after_valid", 32'(chan_b_valid), 32'd0);
        chk("ts_after_info", 32'(chan_b_info), 32'd0);

        // Event + timestamp reset together share one slot
        req_evt_reset = 1'b1;
        req_ts_reset  = 1'b1;
        tick();
        clear_reqs();
        chk("both_valid", 32'(chan_b_valid), 32'd1);
        chk("both_info", 32'(chan_b_info), 32'h0A);
        chk("both_ecr", 32'(evt_count_reset), 32'd1);
        chk("both_pending", 32'(pending), 32'd0);
        tick();
        chk("both_ecr_off", 32'(evt_count_reset), 32'd0);
        wait_idle("both_idle");

        // Event reset alone
        req_evt_reset = 1'b1;
        tick();
        clear_reqs();
        chk("evt_valid", 32'(chan_b_valid), 32'd1);
        chk("evt_info", 32'(chan_b_info), 32'h00);
        chk("evt_ecr", 32'(evt_count_reset), 32'd1);
        wait_idle("evt_idle");

        // Fill, then ts backlog, then two fills in the gap (coalesced, last wins)
        req_fill      = 1'b1;
        req_fill_type = 2'b10;
        tick();
        clear_reqs();
        chk("bk_fill_valid", 32'(chan_b_valid), 32'd1);
        chk("bk_fill_info", 32'(chan_b_info), 32'h30);
        req_ts_reset = 1'b1;
        tick();
        clear_reqs();
        chk("bk_pend_ts", 32'(pending), 32'b010);
        req_fill      = 1'b1;
        req_fill_type = 2'b01;
        tick();
        req_fill_type = 2'b11;
        tick();
        clear_reqs();
        chk("bk_pend_both", 32'(pending), 32'b110);
        chk("bk_coal", 32'(coalesce_count), 32'd1);
        run_quiet(GAP - 4, nv);
        chk("bk_gap1_quiet", 32'(nv), 32'd0);
        tick();
        chk("bk_ts_valid", 32'(chan_b_valid), 32'd1);
        chk("bk_ts_info", 32'(chan_b_info), 32'h0A);
        chk("bk_ts_ecr", 32'(evt_count_reset), 32'd0);
        chk("bk_pend_fill", 32'(pending), 32'b100);
        run_quiet(GAP - 1, nv);
        chk("bk_gap2_quiet", 32'(nv), 32'd0);
        tick();
        chk("bk_fill2_valid", 32'(chan_b_valid), 32'd1);
        chk("bk_fill2_info", 32'(chan_b_info), 32'h38);
        chk("bk_pend_none", 32'(pending), 32'd0);
        chk("bk_coal_final", 32'(coalesce_count), 32'd1);
        chk("bk_drop", 32'(drop_count), 32'd0);
        wait_idle("bk_idle");

        // Illegal fill type is dropped; a legal one follows
        req_fill      = 1'b1;
        req_fill_type = 2'b00;
        tick();
        clear_reqs();
        chk("f00_valid", 32'(chan_b_valid), 32'd0);
        chk("f00_busy", 32'(busy), 32'd0);
        chk("f00_pending", 32'(pending), 32'd0);
        chk("f00_drop", 32'(drop_count), 32'd1);
        req_fill      = 1'b1;
        req_fill_type = 2'b01;
        tick();
        clear_reqs();
        chk("f01_valid", 32'(chan_b_valid), 32'd1);
        chk("f01_info", 32'(chan_b_info), 32'h28);
        wait_idle("f01_idle");

        // Disable during gap with a fill pending
        req_fill      = 1'b1;
        req_fill_type = 2'b10;
        tick();
        clear_reqs();
        chk("dis_strobe", 32'(chan_b_valid), 32'd1);
        tick();
        req_fill      = 1'b1;
        req_fill_type = 2'b11;
        tick();
        clear_reqs();
        chk("dis_pend_set", 32'(pending), 32'b100);
        run_quiet(3, nv);
        enable = 1'b0;
        tick();
        chk("dis_pending", 32'(pending), 32'd0);
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_valid", 32'(chan_b_valid), 32'd0);
        req_evt_reset = 1'b1;
        req_ts_reset  = 1'b1;
        tick();
        clear_reqs();
        req_fill      = 1'b1;
        req_fill_type = 2'b10;
        tick();
        clear_reqs();
        chk("dis_drop", 32'(drop_count), 32'd4);
        chk("dis_pend_after", 32'(pending), 32'd0);
        run_quiet(GAP + 4, nv);
        chk("dis_quiet", 32'(nv), 32'd0);
        enable       = 1'b1;
        req_ts_reset = 1'b1;
        tick();
        clear_reqs();
        chk("reen_valid", 32'(chan_b_valid), 32'd1);
        chk("reen_info", 32'(chan_b_info), 32'h0A);
        chk("reen_busy", 32'(busy), 32'd1);

        // Reset mid-gap with a request pending
        run_quiet(5, nv);
        req_fill      = 1'b1;
        req_fill_type = 2'b01;
        tick();
        clear_reqs();
        chk("rg_pend", 32'(pending), 32'b100);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rg_valid", 32'(chan_b_valid), 32'd0);
        chk("rg_busy", 32'(busy), 32'd0);
        chk("rg_pending", 32'(pending), 32'd0);
        chk("rg_drop", 32'(drop_count), 32'd0);
        chk("rg_coal", 32'(coalesce_count), 32'd0);
        tick();
        chk("rg_no_strobe", 32'(chan_b_valid), 32'd0);
        req_evt_reset = 1'b1;
        tick();
        clear_reqs();
        chk("rg_next_valid", 32'(chan_b_valid), 32'd1);
        chk("rg_next_info", 32'(chan_b_info), 32'h00);
        chk("rg_next_ecr", 32'(evt_count_reset), 32'd1);
        wait_idle("rg_idle");

        // Drop counter saturates at all-ones
        enable        = 1'b0;
        req_evt_reset = 1'b1;
        req_ts_reset  = 1'b1;
        req_fill      = 1'b1;
        req_fill_type = 2'b01;
        tick();
        chk("sat_step", 32'(drop_count), 32'd3);
        tick();
        tick();
        chk("sat_drop", 32'(drop_count), 32'd7);
        clear_reqs();
        enable        = 1'b1;
        req_fill      = 1'b1;
        req_fill_type = 2'b00;
        tick();
        clear_reqs();
        chk("sat_hold", 32'(drop_count), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
